key_debounce_multi: RTL and testbench
=====================================

Name: key_debounce_multi

Overview:
Parametrised multi-channel key debouncer for active-low push buttons on a 50 MHz system clock. Each channel has a two-flop synchroniser, a per-channel stable-time counter and a two-state FSM. Each channel outputs a debounced level, a one-cycle press pulse, a one-cycle release pulse, a long-press pulse and a wrapping press count. It feeds VGA picture-select and mode-control logic, which consume the pulses directly.

Parameters:
NUM_KEYS, 4, number of independent key channels (1..16)
CLK_HZ, 50_000_000, system clock frequency in Hz
DEBOUNCE_MS, 20, time a new input level must stay stable before it is accepted
LONG_MS, 1000, hold time after an accepted press that raises long_press
CNT_W, 8, width of each per-channel press counter

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
key_in  input  NUM_KEYS  raw keys, active low (0 = pressed), asynchronous to clk
key_level  output  NUM_KEYS  debounced level, active low, same polarity as key_in
key_press  output  NUM_KEYS  one-cycle pulse when a press is accepted
key_release  output  NUM_KEYS  one-cycle pulse when a release is accepted
long_press  output  NUM_KEYS  one-cycle pulse when a press has been held LONG_MS after acceptance
press_cnt  output  NUM_KEYS*CNT_W  per-channel accepted-press counters; channel i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Derived constants: DB_MAX = CLK_HZ/1000*DEBOUNCE_MS - 1 and LONG_MAX = CLK_HZ/1000*LONG_MS - 1.
- Counter width is $clog2 of the larger constant plus 1.
- Reset (asynchronous, rst_n=0) forces every channel as follows:
  - synchroniser flops = 1, key_level = 1;
  - all pulses = 0, press_cnt = 0;
  - FSM = RELEASED, debounce counter = 0, long counter = 0, long_done = 0.
- Reset asserted mid-debounce or mid-hold abandons the operation silently; no pulse is emitted.
- Synchroniser: 2 flops per bit; s = second flop. All FSM decisions use s only.
- FSM per channel, states RELEASED and PRESSED:
  - RELEASED, s=1: debounce counter cleared to 0.
  - RELEASED, s=0: counter increments.
    - When counter == DB_MAX and s is still 0: next cycle key_level<=0, key_press<=1 for one cycle, press_cnt<=press_cnt+1, state<=PRESSED, counter<=0, long counter<=0, long_done<=0.
  - PRESSED, s=0: debounce counter cleared to 0.
    - The long counter increments while long_done=0.
    - When long counter == LONG_MAX: long_press<=1 for one cycle and long_done<=1. There is no repeat within one press.
  - PRESSED, s=1: debounce counter increments.
    - When counter == DB_MAX: key_level<=1, key_release<=1 for one cycle, state<=RELEASED, counter<=0.
  - Any glitch back to the current accepted level before DB_MAX restarts the debounce count from 0 and emits no pulse.
- Latency: a clean edge on key_in reaches key_level/key_press 2 sync cycles + DB_MAX+1 cycles + 1 register cycle later. All outputs are registered.
- press_cnt wraps modulo 2^CNT_W (255 -> 0) with no saturation or flag.
- A release accepted in the same cycle the long counter hits LONG_MAX: the release wins. The FSM leaves PRESSED and long_press is not emitted.
- key_press, key_release and long_press are mutually exclusive on a channel in any cycle.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Illegal FSM encoding returns to RELEASED with key_level=1.

Test Plan:
- Reset: hold rst_n=0 with key_in=0 -> key_level all 1, press_cnt 0, no pulses. Release reset, hold key_in[0]=0 -> key_press[0] exactly once, DB_MAX+4 cycles after the edge.
- Bounce rejection, sim override DEBOUNCE_MS with CLK_HZ=1000 (DB_MAX=DEBOUNCE_MS-1, set to 5 -> DB_MAX=4): toggle key_in[1] every 3 cycles for 30 cycles, then hold 0 -> a single key_press[1] only after the hold, press_cnt[1]=1.
- Release: after an accepted press, bounce to 1 for 2 cycles then back to 0 -> no key_release. Then hold 1 -> one key_release[1], key_level[1]=1.
- Long press with LONG_MAX=19: hold key 2 pressed for 50 cycles -> exactly one long_press[2], 20 cycles after key_press[2]. A 10-cycle hold -> no long_press.
- Wrap: 256 accepted presses on key 3 with CNT_W=8 -> press_cnt[3]=0. One more press -> 1.
- Concurrency and mid-operation reset:
  - Press keys 0 and 3 simultaneously -> both key_press bits high in the same cycle.
  - Assert rst_n mid-debounce -> no pulse, counters 0, and normal operation after deassertion.

Source files
------------

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: multi-channel debouncer for active-low push buttons.
// Each channel runs a two-flop synchroniser, a stable-time counter, a
// two-state press FSM, a long-press timer and a wrapping press counter.
// Decisions taken by the FSM are registered once as events and then once
// more into the output registers, so every output is a plain flop.
module key_debounce_multi #(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_KEYS-1:0]       key_in,
  output logic [NUM_KEYS-1:0]       key_level,
  output logic [NUM_KEYS-1:0]       key_press,
  output logic [NUM_KEYS-1:0]       key_release,
  output logic [NUM_KEYS-1:0]       long_press,
  output logic [NUM_KEYS*CNT_W-1:0] press_cnt
);

  // Terminal counts: a level must be seen DB_MAX+1 consecutive cycles to be
  // accepted, and a press must be held LONG_MAX+1 cycles to count as long.
  localparam int DB_MAX   = CLK_HZ / 1000 * DEBOUNCE_MS - 1;
  localparam int LONG_MAX = CLK_HZ / 1000 * LONG_MS - 1;
  localparam int BIG_MAX  = (DB_MAX > LONG_MAX) ? DB_MAX : LONG_MAX;
  localparam int CW       = $clog2(BIG_MAX) + 1;

  localparam logic [CW-1:0] DB_TOP   = CW'(DB_MAX);
  localparam logic [CW-1:0] LONG_TOP = CW'(LONG_MAX);

  // One-hot style encoding leaves two unused codes; both fall back to RELEASED.
  typedef enum logic [1:0] {
    ST_RELEASED = 2'b01,
    ST_PRESSED  = 2'b10
  } state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key

    logic          sync_a;
    logic          sync_s;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] db_cnt;
    logic [CW-1:0] db_nxt;
    logic [CW-1:0] long_cnt;
    logic [CW-1:0] long_nxt;
    logic          long_done;
    logic          long_done_nxt;
    logic          press_evt;
    logic          release_evt;
    logic          long_evt;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          level_r;
    logic          press_r;
    logic          release_r;
    logic          long_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-flop synchroniser; idles high so a reset looks like "not pressed".
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_a <= 1'b1;
        sync_s <= 1'b1;
      end else begin
        sync_a <= key_in[i];
        sync_s <= sync_a;
      end
    end

    // FSM state register together with the debounce and long-press timers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= ST_RELEASED;
        db_cnt    <= '0;
        long_cnt  <= '0;
        long_done <= 1'b0;
      end else begin
        state     <= state_nxt;
        db_cnt    <= db_nxt;
        long_cnt  <= long_nxt;
        long_done <= long_done_nxt;
      end
    end

    // Next-state logic: count while the synchronised input disagrees with
    // the accepted level, restart on any return to it. The long timer runs
    // for the whole time the press is accepted and stops once it has fired.
    always_comb begin
      state_nxt     = state;
      db_nxt        = db_cnt;
      long_nxt      = long_cnt;
      long_done_nxt = long_done;
      unique case (state)
        ST_RELEASED: begin
          if (sync_s) begin
            db_nxt = '0;
          end else if (db_cnt == DB_TOP) begin
            state_nxt     = ST_PRESSED;
            db_nxt        = '0;
            long_nxt      = '0;
            long_done_nxt = 1'b0;
          end else begin
            db_nxt = db_cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!sync_s) begin
            db_nxt = '0;
          end else if (db_cnt == DB_TOP) begin
            state_nxt = ST_RELEASED;
            db_nxt    = '0;
          end else begin
            db_nxt = db_cnt + 1'b1;
          end
          if (!(sync_s && db_cnt == DB_TOP) && !long_done) begin
            if (long_cnt == LONG_TOP) begin
              long_done_nxt = 1'b1;
            end else begin
              long_nxt = long_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nxt     = ST_RELEASED;
          db_nxt        = '0;
          long_nxt      = '0;
          long_done_nxt = 1'b0;
        end
      endcase
    end

    // Event decode; an accepted release masks a long press in the same cycle.
    always_comb begin
      press_evt   = 1'b0;
      release_evt = 1'b0;
      long_evt    = 1'b0;
      if (state == ST_RELEASED) begin
        press_evt = !sync_s && (db_cnt == DB_TOP);
      end else if (state == ST_PRESSED) begin
        release_evt = sync_s && (db_cnt == DB_TOP);
        long_evt    = !release_evt && !long_done && (long_cnt == LONG_TOP);
      end
    end

    // Event register, captured on the same edge that moves the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        press_q   <= press_evt;
        release_q <= release_evt;
        long_q    <= long_evt;
      end
    end

    // Output register: level follows the FSM, pulses follow the events and
    // the press counter simply wraps.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_r   <= 1'b1;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        cnt_r     <= '0;
      end else begin
        level_r   <= (state != ST_PRESSED);
        press_r   <= press_q;
        release_r <= release_q;
        long_r    <= long_q;
        cnt_r     <= cnt_r + CNT_W'(press_q);
      end
    end

    assign key_level[i]                  = level_r;
    assign key_press[i]                  = press_r;
    assign key_release[i]                = release_r;
    assign long_press[i]                 = long_r;
    assign press_cnt[i*CNT_W +: CNT_W]   = cnt_r;

  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: directed scenarios plus random key traffic, all
// compared every cycle against a run-length reference model.
module tb_key_debounce_multi;

  localparam int NK       = 4;
  localparam int CLKHZ    = 1000;
  localparam int DEB_MS   = 5;
  localparam int LNG_MS   = 20;
  localparam int CW8      = 8;
  localparam int DB_MAX   = CLKHZ / 1000 * DEB_MS - 1;
  localparam int LONG_MAX = CLKHZ / 1000 * LNG_MS - 1;

  logic                clk;
  logic                rst_n;
  logic [NK-1:0]       key_in;
  logic [NK-1:0]       key_level;
  logic [NK-1:0]       key_press;
  logic [NK-1:0]       key_release;
  logic [NK-1:0]       long_press;
  logic [NK*CW8-1:0]   press_cnt;

  int checks = 0;
  int errors = 0;

  key_debounce_multi #(
    .NUM_KEYS(NK), .CLK_HZ(CLKHZ), .DEBOUNCE_MS(DEB_MS),
    .LONG_MS(LNG_MS), .CNT_W(CW8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_level(key_level),
    .key_press(key_press), .key_release(key_release),
    .long_press(long_press), .press_cnt(press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: an input level is accepted once the synchronised input
  // has disagreed with the accepted level for DB_MAX+1 cycles in a row; a
  // long press fires LONG_MAX+1 cycles after acceptance if still held.
  // Outputs show the decision one clock later.
  bit        h1 [NK];
  bit        h2 [NK];
  bit        acc [NK];
  int        run [NK];
  int        pedge [NK];
  bit        fired [NK];
  bit        pp [NK];
  bit        pr [NK];
  bit        pl [NK];
  int        cyc;
  logic [NK-1:0]  exp_level, exp_press, exp_rel, exp_long;
  logic [CW8-1:0] exp_cnt [NK];

  task automatic modelStep();
    bit s;
    if (!rst_n) begin
      for (int k = 0; k < NK; k++) begin
        h1[k] = 1; h2[k] = 1; acc[k] = 1; run[k] = 0; pedge[k] = 0;
        fired[k] = 1; pp[k] = 0; pr[k] = 0; pl[k] = 0; exp_cnt[k] = '0;
      end
      exp_level = '1; exp_press = '0; exp_rel = '0; exp_long = '0;
      cyc = 0;
    end else begin
      cyc++;
      for (int k = 0; k < NK; k++) begin
        exp_level[k] = acc[k];
        exp_press[k] = pp[k];
        exp_rel[k]   = pr[k];
        exp_long[k]  = pl[k];
        if (pp[k]) exp_cnt[k] = exp_cnt[k] + 1'b1;
        s = h2[k];
        h2[k] = h1[k];
        h1[k] = key_in[k];
        pp[k] = 0; pr[k] = 0; pl[k] = 0;
        run[k] = (s != acc[k]) ? run[k] + 1 : 0;
        if (run[k] == DB_MAX + 1) begin
          run[k] = 0;
          acc[k] = s;
          if (!s) begin
            pp[k] = 1; pedge[k] = cyc; fired[k] = 0;
          end else begin
            pr[k] = 1;
          end
        end else if (!acc[k] && !fired[k] && (cyc - pedge[k] == LONG_MAX + 1)) begin
          pl[k] = 1;
          fired[k] = 1;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    modelStep();
    forever begin
      @(posedge clk or negedge rst_n);
      modelStep();
    end
  end

  // Every-cycle comparison against the model, plus pulse tallies for the
  // directed scenarios.
  int press_seen [NK];
  int rel_seen [NK];
  int long_seen [NK];

  initial begin
    logic [NK*CW8-1:0] ecnt;
    for (int k = 0; k < NK; k++) begin
      press_seen[k] = 0; rel_seen[k] = 0; long_seen[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
        ecnt[k*CW8 +: CW8] = exp_cnt[k];
        if (key_press[k] === 1'b1)   press_seen[k]++;
        if (key_release[k] === 1'b1) rel_seen[k]++;
        if (long_press[k] === 1'b1)  long_seen[k]++;
      end
      checkOutput("level", 32'(key_level), 32'(exp_level));
      checkOutput("press", 32'(key_press), 32'(exp_press));
      checkOutput("release", 32'(key_release), 32'(exp_rel));
      checkOutput("long", 32'(long_press), 32'(exp_long));
      checkOutput("count", press_cnt, ecnt);
    end
  end

  task automatic waitCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [NK-1:0] keys, input int cycles);
    key_in = keys;
    repeat (cycles) waitCycle();
  endtask

  // Cycles from now until key_press[k] is seen, 0 if it never comes.
  task automatic pressLatency(input int k, output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (key_press[k] === 1'b1) begin
        lat = i;
        break;
      end
    end
    #1;
  endtask

  initial begin
    int lat, base, pi, li;
    logic [CW8-1:0] c3;
    key_in = '0;
    rst_n  = 1'b0;
    repeat (5) waitCycle();
    checkOutput("rst_level", 32'(key_level), 32'hF);
    checkOutput("rst_cnt", press_cnt, 32'h0);
    checkOutput("rst_pulse", 32'(key_press | key_release | long_press), 32'h0);

    // Reset release with key 0 already down.
    key_in = 4'hE;
    rst_n  = 1'b1;
    pressLatency(0, lat);
    checkOutput("press_latency", 32'(lat), 32'(DB_MAX + 4));
    applyStimulus(4'hE, 30);
    checkOutput("press_once", 32'(press_seen[0]), 32'd1);
    applyStimulus(4'hF, 12);

    // Bounce on key 1, then a clean hold.
    base = press_seen[1];
    for (int n = 0; n < 5; n++) begin
      applyStimulus(4'hD, 3);
      applyStimulus(4'hF, 3);
    end
    checkOutput("bounce_nopress", 32'(press_seen[1] - base), 32'd0);
    applyStimulus(4'hD, 12);
    checkOutput("bounce_press", 32'(press_seen[1] - base), 32'd1);
    checkOutput("bounce_cnt1", 32'(press_cnt[15:8]), 32'd1);

    // Short release glitch is rejected, a clean release is accepted.
    base = rel_seen[1];
    applyStimulus(4'hF, 2);
    applyStimulus(4'hD, 10);
    checkOutput("rel_glitch", 32'(rel_seen[1] - base), 32'd0);
    applyStimulus(4'hF, 12);
    checkOutput("rel_clean", 32'(rel_seen[1] - base), 32'd1);
    checkOutput("rel_level", 32'(key_level[1]), 32'd1);

    // Long press on key 2.
    base = long_seen[2];
    pi = 0; li = 0;
    key_in = 4'hB;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      #1;
      if (key_press[2] === 1'b1) pi = i;
      if (long_press[2] === 1'b1) li = i;
    end
    #1;
    checkOutput("long_seen", 32'(pi != 0 && li != 0), 32'd1);
    checkOutput("long_delay", 32'(li - pi), 32'(LONG_MAX + 1));
    checkOutput("long_once", 32'(long_seen[2] - base), 32'd1);
    applyStimulus(4'hF, 12);
    base = long_seen[2];
    applyStimulus(4'hB, 10);
    applyStimulus(4'hF, 12);
    checkOutput("short_nolong", 32'(long_seen[2] - base), 32'd0);

    // Keys 0 and 3 together.
    key_in = 4'h6;
    pressLatency(0, lat);
    checkOutput("concurrent", 32'(key_press & 4'h9), 32'h9);
    applyStimulus(4'h6, 5);
    applyStimulus(4'hF, 12);

    // Reset in the middle of a debounce.
    base = press_seen[0];
    applyStimulus(4'hE, 4);
    rst_n = 1'b0;
    repeat (3) waitCycle();
    checkOutput("midrst_cnt", press_cnt, 32'h0);
    checkOutput("midrst_level", 32'(key_level), 32'hF);
    checkOutput("midrst_nopulse", 32'(press_seen[0] - base), 32'd0);
    rst_n = 1'b1;
    pressLatency(0, lat);
    checkOutput("midrst_resume", 32'(lat), 32'(DB_MAX + 4));
    applyStimulus(4'hF, 12);
    checkOutput("midrst_cnt_after", press_cnt, 32'h1);

    // Wrap the key 3 counter.
    for (int n = 0; n < 256; n++) begin
      applyStimulus(4'h7, 9);
      applyStimulus(4'hF, 9);
    end
    c3 = press_cnt[31:24];
    checkOutput("wrap_zero", 32'(c3), 32'd0);
    applyStimulus(4'h7, 9);
    applyStimulus(4'hF, 9);
    c3 = press_cnt[31:24];
    checkOutput("wrap_one", 32'(c3), 32'd1);

    // Random traffic, checked by the model every cycle.
    for (int n = 0; n < 250; n++) begin
      applyStimulus(4'($urandom), int'($urandom_range(1, 12)));
    end
    applyStimulus(4'hF, 20);
    checkOutput("final_level", 32'(key_level), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
